// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial frame transmitter and the matching receivers.
// Holds the state encoding, the idle line level and a counter-width helper.
package serial_frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam logic LINE_IDLE = 1'b1;

    // A one-bit word still needs a one-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_frame_tx_shreg.sv
// Loadable right-shift register with even-parity capture on load.
// Exposes next-cycle LSB and parity so the FSM can register its line output.
module serial_frame_tx_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             lsb_nxt_o,
    output logic             par_nxt_o
);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             par_q, par_d;

    always_comb begin
        shreg_d = shreg_q;
        par_d   = par_q;
        if (load_i) begin
            shreg_d = din_i;
            par_d   = ^din_i;
        end else if (shift_i) begin
            shreg_d = shreg_q >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            par_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            par_q   <= par_d;
        end
    end

    assign lsb_nxt_o = shreg_d[0];
    assign par_nxt_o = par_d;

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framed transmitter: start bit, data LSB first, optional even parity, stop bits.
// All outputs are registered from the next-state decode, so no input reaches an output combinationally.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PARITY_EN = 1,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             stop_cnt_q, stop_cnt_d;
    logic             dout_q, dout_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load, shift;
    logic             lsb_nxt, par_nxt;

    serial_frame_tx_shreg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .shift_i  (shift),
        .din_i    (din),
        .lsb_nxt_o(lsb_nxt),
        .par_nxt_o(par_nxt)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        load       = 1'b0;
        shift      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (din_valid && ready_q) begin
                    load    = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                bit_cnt_d = '0;
                state_d   = ST_DATA;
            end
            ST_DATA: begin
                shift = 1'b1;
                if (bit_cnt_q == BIT_LAST) begin
                    stop_cnt_d = 1'b0;
                    state_d    = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                stop_cnt_d = 1'b0;
                state_d    = ST_STOP;
            end
            ST_STOP: begin
                if (stop_cnt_q == STOP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Output decode of the state being entered, registered below.
        dout_d  = LINE_IDLE;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        case (state_d)
            ST_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            ST_START:  dout_d = 1'b0;
            ST_DATA:   dout_d = lsb_nxt;
            ST_PARITY: dout_d = par_nxt;
            ST_STOP:   done_d = (stop_cnt_d == STOP_LAST);
            default:   busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            dout_q     <= LINE_IDLE;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            dout_q     <= dout_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign dout      = dout_q;
    assign din_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two instances (parity/1 stop and no-parity/2 stop) checked
// against a frame model built from the framing rules.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din_a, din_b;
    logic       vld_a, vld_b;
    logic       rdy_a, rdy_b, dout_a, dout_b, busy_a, busy_b, done_a, done_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_frame_tx #(.WIDTH(8), .PARITY_EN(1), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(vld_a),
        .din_ready(rdy_a), .dout(dout_a), .busy(busy_a), .done(done_a)
    );

    serial_frame_tx #(.WIDTH(8), .PARITY_EN(0), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(vld_b),
        .din_ready(rdy_b), .dout(dout_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic o_dout(input int w); return (w == 0) ? dout_a : dout_b; endfunction
    function automatic logic o_rdy (input int w); return (w == 0) ? rdy_a  : rdy_b;  endfunction
    function automatic logic o_busy(input int w); return (w == 0) ? busy_a : busy_b; endfunction
    function automatic logic o_done(input int w); return (w == 0) ? done_a : done_b; endfunction

    task automatic chk_idle(input int w, input string tag);
        chk($sformatf("%s_dout%0d", tag, w), 32'(o_dout(w)), 32'd1);
        chk($sformatf("%s_ready%0d", tag, w), 32'(o_rdy(w)), 32'd1);
        chk($sformatf("%s_busy%0d", tag, w), 32'(o_busy(w)), 32'd0);
        chk($sformatf("%s_done%0d", tag, w), 32'(o_done(w)), 32'd0);
    endtask

    task automatic drive(input int w, input logic [7:0] d, input logic v);
        if (w == 0) begin din_a = d; vld_a = v; end
        else        begin din_b = d; vld_b = v; end
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge after the frame.
    task automatic send(input int w, input logic [7:0] d, input logic [7:0] nxt, input bit hold);
        bit exp[$];
        int par_en = (w == 0) ? 1 : 0;
        int stops  = (w == 0) ? 1 : 2;
        int ones   = 0;
        exp.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par_en != 0) exp.push_back(ones % 2 == 1);
        for (int i = 0; i < stops; i++) exp.push_back(1'b1);

        chk($sformatf("pre_ready%0d_%h", w, d), 32'(o_rdy(w)), 32'd1);
        chk($sformatf("pre_busy%0d_%h", w, d), 32'(o_busy(w)), 32'd0);
        chk($sformatf("pre_dout%0d_%h", w, d), 32'(o_dout(w)), 32'd1);
        drive(w, d, 1'b1);
        @(negedge clk);
        drive(w, nxt, hold);
        for (int i = 0; i < exp.size(); i++) begin
            chk($sformatf("dout%0d_%h_c%0d", w, d, i), 32'(o_dout(w)), 32'(exp[i]));
            chk($sformatf("busy%0d_%h_c%0d", w, d, i), 32'(o_busy(w)), 32'd1);
            chk($sformatf("ready%0d_%h_c%0d", w, d, i), 32'(o_rdy(w)), 32'd0);
            chk($sformatf("done%0d_%h_c%0d", w, d, i), 32'(o_done(w)),
                32'(i == exp.size() - 1));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] r;
        rst = 1'b1;
        din_a = 8'hA5; vld_a = 1'b1;
        din_b = 8'hFF; vld_b = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk_idle(0, "rst");
            chk_idle(1, "rst");
        end
        rst = 1'b0;
        vld_a = 1'b0;
        vld_b = 1'b0;
        @(negedge clk);
        chk_idle(0, "post_rst");
        chk_idle(1, "post_rst");

        send(0, 8'hA5, 8'h00, 1'b0);
        chk_idle(0, "after_a5");
        send(0, 8'h07, 8'h00, 1'b0);
        send(1, 8'hFF, 8'h00, 1'b0);
        chk_idle(1, "after_ff");

        // Back-to-back with valid held: the mid-frame word waits for the IDLE cycle.
        send(0, 8'h01, 8'h80, 1'b1);
        send(0, 8'h80, 8'h00, 1'b0);
        send(1, 8'h01, 8'h80, 1'b1);
        send(1, 8'h80, 8'h00, 1'b0);

        // Reset during the 4th DATA cycle.
        drive(0, 8'hC3, 1'b1);
        @(negedge clk);
        drive(0, 8'h00, 1'b0);
        repeat (4) @(negedge clk);
        chk("mid_busy_before_rst", 32'(busy_a), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle(0, "mid_rst");
        repeat (3) begin
            @(negedge clk);
            chk_idle(0, "mid_rst_hold");
        end
        send(0, 8'h3C, 8'h00, 1'b0);

        for (int k = 0; k < 8; k++) begin
            r = 8'($urandom);
            send(k % 2, r, 8'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
